// File: rtl/conv_output_streamer.sv
// Captures the conv2d output bus on start and replays it as indexed, coordinate-tagged valid/ready words.
// First word is valid the cycle after start, one word per accepted cycle; a stalled word holds until accepted.
module conv_output_streamer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BATCH_SIZE   = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int OUT_HEIGHT   = 2,
  parameter int OUT_WIDTH    = 2,
  localparam int NUM_ELEMS   = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH,
  localparam int IDX_W       = (NUM_ELEMS > 1)    ? $clog2(NUM_ELEMS)    : 1,
  localparam int B_W         = (BATCH_SIZE > 1)   ? $clog2(BATCH_SIZE)   : 1,
  localparam int C_W         = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
  localparam int R_W         = (OUT_HEIGHT > 1)   ? $clog2(OUT_HEIGHT)   : 1,
  localparam int W_W         = (OUT_WIDTH > 1)    ? $clog2(OUT_WIDTH)    : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0] output_tensor_flat,
  output logic                            busy,
  output logic                            done,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [IDX_W-1:0]                m_index,
  output logic [B_W-1:0]                  m_batch,
  output logic [C_W-1:0]                  m_chan,
  output logic [R_W-1:0]                  m_row,
  output logic [W_W-1:0]                  m_col,
  output logic                            m_last
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  typedef struct packed {
    logic [B_W-1:0] batch;
    logic [C_W-1:0] chan;
    logic [R_W-1:0] row;
    logic [W_W-1:0] col;
  } coord_t;

  state_t                state_q, state_nxt;
  logic                  capture, xfer;
  logic [DATA_WIDTH-1:0] snap [NUM_ELEMS];
  coord_t                coord_q, coord_nxt;
  logic [IDX_W-1:0]      idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // start is only honoured in IDLE, so a pulse while streaming or in DONE never re-captures
  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    xfer      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (m_ready) begin
          xfer = 1'b1;
          if (m_last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state_q == STREAM);
  assign m_valid = (state_q == STREAM);
  assign done    = (state_q == DONE);

  assign idx_nxt = m_index + 1'b1;

  // Column-fastest odometer; each field wraps into the next slower one
  always_comb begin
    coord_nxt = coord_q;
    if (coord_q.col != W_W'(OUT_WIDTH - 1)) begin
      coord_nxt.col = coord_q.col + 1'b1;
    end else begin
      coord_nxt.col = '0;
      if (coord_q.row != R_W'(OUT_HEIGHT - 1)) begin
        coord_nxt.row = coord_q.row + 1'b1;
      end else begin
        coord_nxt.row = '0;
        if (coord_q.chan != C_W'(OUT_CHANNELS - 1)) begin
          coord_nxt.chan = coord_q.chan + 1'b1;
        end else begin
          coord_nxt.chan  = '0;
          coord_nxt.batch = coord_q.batch + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ELEMS; i++) snap[i] <= '0;
      coord_q <= '0;
      m_index <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (capture) begin
      for (int i = 0; i < NUM_ELEMS; i++) snap[i] <= output_tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
      coord_q <= '0;
      m_index <= '0;
      m_data  <= output_tensor_flat[DATA_WIDTH-1:0];
      m_last  <= (NUM_ELEMS == 1);
    end else if (xfer) begin
      if (m_last) begin
        m_last <= 1'b0;
      end else begin
        coord_q <= coord_nxt;
        m_index <= idx_nxt;
        m_data  <= snap[idx_nxt];
        m_last  <= (idx_nxt == IDX_W'(NUM_ELEMS - 1));
      end
    end
  end

  assign m_batch = coord_q.batch;
  assign m_chan  = coord_q.chan;
  assign m_row   = coord_q.row;
  assign m_col   = coord_q.col;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Directed and randomized checks of conv_output_streamer in a 1x1x2x2 and a 2x2x2x3 configuration.
module tb_conv_output_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, ready_a, start_b, ready_b;
  logic [4*32-1:0]  flat_a;
  logic [24*32-1:0] flat_b;

  logic busy_a, done_a, valid_a, last_a;
  logic [31:0] data_a;
  logic [1:0]  index_a;
  logic batch_a, chan_a, row_a, col_a;

  logic busy_b, done_b, valid_b, last_b;
  logic [31:0] data_b;
  logic [4:0]  index_b;
  logic batch_b, chan_b, row_b;
  logic [1:0]  col_b;

  conv_output_streamer u_a (
    .clk(clk), .rst(rst), .start(start_a), .output_tensor_flat(flat_a),
    .busy(busy_a), .done(done_a), .m_valid(valid_a), .m_ready(ready_a),
    .m_data(data_a), .m_index(index_a), .m_batch(batch_a), .m_chan(chan_a),
    .m_row(row_a), .m_col(col_a), .m_last(last_a)
  );

  conv_output_streamer #(
    .DATA_WIDTH(32), .BATCH_SIZE(2), .OUT_CHANNELS(2), .OUT_HEIGHT(2), .OUT_WIDTH(3)
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b), .output_tensor_flat(flat_b),
    .busy(busy_b), .done(done_b), .m_valid(valid_b), .m_ready(ready_b),
    .m_data(data_b), .m_index(index_b), .m_batch(batch_b), .m_chan(chan_b),
    .m_row(row_b), .m_col(col_b), .m_last(last_b)
  );

  // Selected instance's outputs, so one reference model serves both configurations
  bit sel;
  logic o_valid, o_busy, o_done, o_last;
  logic [31:0] o_data, o_index, o_batch, o_chan, o_row, o_col;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_last  = sel ? last_b  : last_a;
  assign o_data  = sel ? data_b  : data_a;
  assign o_index = sel ? 32'(index_b) : 32'(index_a);
  assign o_batch = sel ? 32'(batch_b) : 32'(batch_a);
  assign o_chan  = sel ? 32'(chan_b)  : 32'(chan_a);
  assign o_row   = sel ? 32'(row_b)   : 32'(row_a);
  assign o_col   = sel ? 32'(col_b)   : 32'(col_a);

  logic [31:0] exp_data [24];
  bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
  int total, passed, failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_ready(input logic v);
    if (sel) ready_b = v; else ready_a = v;
  endtask

  task automatic load_bus(input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) flat_b[i*32 +: 32] = exp_data[i];
      else     flat_a[i*32 +: 32] = exp_data[i];
    end
  endtask

  task automatic rand_data(input int n);
    for (int i = 0; i < n; i++) exp_data[i] = $urandom;
    load_bus(n);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_busy"},  o_busy,  0);
    check({tag, "_done"},  o_done,  0);
  endtask

  // mode 0: ready always high, 1: fixed toggle pattern, 2: random ready
  task automatic stream(input int n, input int ow, input int oh, input int oc,
                        input int mode, input bit corrupt, input bit poke);
    int  k, cyc;
    bit  rdy, got;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    k = 0; cyc = 0; got = 0;
    while (!got && cyc < 400) begin
      if (o_done) begin
        got = 1;
        check("done_word_count", k, n);
        check("done_valid", o_valid, 0);
        check("done_busy",  o_busy,  0);
        check("done_last",  o_last,  0);
      end else begin
        check("valid", o_valid, 1);
        check("busy",  o_busy,  1);
        check("data",  o_data,  (k < 24) ? exp_data[k] : 32'hX);
        check("index", o_index, k);
        check("batch", o_batch, k / (ow * oh * oc));
        check("chan",  o_chan,  (k / (ow * oh)) % oc);
        check("row",   o_row,   (k / ow) % oh);
        check("col",   o_col,   k % ow);
        check("last",  o_last,  (k == n - 1));
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 7] : 1'($urandom_range(0, 1));
        set_ready(rdy);
        if (corrupt && cyc == 0) begin
          if (sel) flat_b = {24{32'hDEADBEEF}};
          else     flat_a = {4{32'hDEADBEEF}};
        end
        if (poke && k == 1) set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        if (rdy) k++;
        cyc++;
      end
    end
    check("done_seen", got, 1);
    if (mode == 0) check("stream_cycles", cyc, n);
    set_ready(1'b0);
    @(posedge clk); #1;
    check_idle("after_done");
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    sel = 0;
    rst = 1'b0;
    start_a = 0; ready_a = 0; start_b = 0; ready_b = 0;
    flat_a = '0; flat_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_a");
    check("reset_a_data",  o_data,  0);
    check("reset_a_index", o_index, 0);
    check("reset_a_last",  o_last,  0);
    sel = 1; #1;
    check_idle("reset_b");
    check("reset_b_data",  o_data,  0);
    check("reset_b_index", o_index, 0);
    check("reset_b_last",  o_last,  0);
    sel = 0; #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic stream, then the same data under backpressure
    exp_data[0] = 32'h11111111; exp_data[1] = 32'h22222222;
    exp_data[2] = 32'h33333333; exp_data[3] = 32'h44444444;
    load_bus(4);
    stream(4, 2, 2, 1, 0, 0, 0);
    stream(4, 2, 2, 1, 1, 0, 0);

    // Bus overwritten one cycle after start must not reach the stream
    stream(4, 2, 2, 1, 0, 1, 0);

    // Start during index 1 is ignored; a start after done replays the current bus
    load_bus(4);
    stream(4, 2, 2, 1, 0, 0, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check_idle("no_second_stream");
    end
    rand_data(4);
    stream(4, 2, 2, 1, 0, 0, 0);

    // Asynchronous reset after index 1 is accepted
    rand_data(4);
    set_start(1'b1);
    ready_a = 1'b1;
    @(posedge clk); #1;
    set_start(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_index", o_index, 2);
    rst = 1'b0;
    #1;
    check_idle("mid_reset");
    check("mid_reset_index", o_index, 0);
    check("mid_reset_data",  o_data,  0);
    @(posedge clk); #1;
    check("mid_reset_no_done", o_done, 0);
    rst = 1'b1;
    ready_a = 1'b0;
    @(posedge clk); #1;
    stream(4, 2, 2, 1, 0, 0, 0);

    repeat (4) begin
      rand_data(4);
      stream(4, 2, 2, 1, 2, 0, 0);
    end

    // Multi-dimensional configuration
    sel = 1; #1;
    for (int i = 0; i < 24; i++) exp_data[i] = 32'(i) + 32'h100;
    load_bus(24);
    stream(24, 3, 2, 2, 0, 0, 0);
    repeat (2) begin
      rand_data(24);
      stream(24, 3, 2, 2, 2, 0, 0);
    end
    stream(24, 3, 2, 2, 1, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
